// File: rtl/cam_stream_if.sv
// cam_stream_if: bundle between the synthetic camera source and whatever
// consumes its stream (capture path or bench).
//   enable      - run/stop request (consumer -> source)
//   mode        - test pattern select (consumer -> source)
//   marker_x/y  - marker square position for mode 3 (consumer -> source)
//   cam_vsync   - frame sync, active high (source -> consumer)
//   href        - active-byte qualifier (source -> consumer)
//   pixel       - YUV422 byte stream, Cb,Y0,Cr,Y1 order (source -> consumer)
//   frame_done  - one-cycle end-of-frame pulse (source -> consumer)
//   frame_count - completed frames, wrapping 8-bit (source -> consumer)
interface cam_stream_if;
   logic       enable;
   logic [1:0] mode;
   logic [9:0] marker_x;
   logic [9:0] marker_y;
   logic       cam_vsync;
   logic       href;
   logic [7:0] pixel;
   logic       frame_done;
   logic [7:0] frame_count;

   modport master (
      input  enable, mode, marker_x, marker_y,
      output cam_vsync, href, pixel, frame_done, frame_count
   );

   modport slave (
      output enable, mode, marker_x, marker_y,
      input  cam_vsync, href, pixel, frame_done, frame_count
   );
endinterface

// File: rtl/cam_stream_source.sv
// cam_stream_source: synthetic parallel YUV422 camera transmitter.
// Produces continuous frames (VSYNC, VBACK, ACTIVE, VFRONT) with one of four
// test patterns: solid gray, colour bars, luma ramp, or a marker square
// bright enough to trip the capture path's colour detector.
// Ports:
//   pclk  - byte clock, everything on its rising edge
//   reset - asynchronous, active-low
//   bus   - cam_stream_if.master (controls in, video/status out)
// All outputs are registered from the current counter/state values, so
// cam_vsync, href, pixel, frame_done and frame_count stay mutually aligned.
module cam_stream_source #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_BLANK     = 144,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10,
   parameter int MARK_SIZE   = 16
) (
   input  logic         pclk,
   input  logic         reset,
   cam_stream_if.master bus
);

   localparam int LINE = 2*H_ACTIVE + H_BLANK;
   localparam int CW   = $clog2(LINE);
   localparam int LW   = 10;
   localparam logic [CW-1:0] CYC_LAST = CW'(LINE - 1);
   localparam logic [CW-1:0] HREF_END = CW'(2*H_ACTIVE);
   localparam logic [10:0]   MS       = 11'(MARK_SIZE);

   typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

   state_t        state_q;
   logic [CW-1:0] cyc_q, cyc_d;
   logic [LW-1:0] line_q, line_d, line_last;
   logic [1:0]    mode_q;
   logic [9:0]    mx_q, my_q;
   logic          vsync_q, href_q, done_q;
   logic [7:0]    pix_q, fcnt_q;

   logic          line_end, blk_end;
   logic          href_d;
   logic [7:0]    pix_d;
   logic [10:0]   xe, xl, ya;
   logic          in_mark;
   logic [23:0]   c_tab, l_tab;
   logic [7:0]    y_v, cb_v, cr_v;

   // Bar index from pixel column; comparators instead of a divider.
   function automatic logic [2:0] bar_of(input logic [10:0] x);
      if      (x < 11'd80)  return 3'd0;
      else if (x < 11'd160) return 3'd1;
      else if (x < 11'd240) return 3'd2;
      else if (x < 11'd320) return 3'd3;
      else if (x < 11'd400) return 3'd4;
      else if (x < 11'd480) return 3'd5;
      else if (x < 11'd560) return 3'd6;
      else                  return 3'd7;
   endfunction

   // {Y, Cb, Cr} per bar.
   function automatic logic [23:0] bar_ycc(input logic [2:0] b);
      case (b)
         3'd0:    return 24'hEB8080;
         3'd1:    return 24'hD21092;
         3'd2:    return 24'hAAA610;
         3'd3:    return 24'h913622;
         3'd4:    return 24'h6ACADE;
         3'd5:    return 24'h515AF0;
         3'd6:    return 24'h29F06E;
         default: return 24'h108080;
      endcase
   endfunction

   always_comb begin
      line_end = (cyc_q == CYC_LAST);
      cyc_d    = line_end ? '0 : cyc_q + 1'b1;
      case (state_q)
         VSYNC:   line_last = LW'(VSYNC_LINES - 1);
         VBACK:   line_last = LW'(V_BACK - 1);
         ACTIVE:  line_last = LW'(V_ACTIVE - 1);
         VFRONT:  line_last = LW'(V_FRONT - 1);
         default: line_last = '0;
      endcase
      blk_end = line_end && (line_q == line_last);
      line_d  = blk_end ? '0 : (line_end ? line_q + 1'b1 : line_q);
   end

   // Pattern generation. Chroma and marker membership follow the pair's even
   // pixel; luma follows the byte's own pixel (odd pixel on phase 3).
   always_comb begin
      xe      = 11'({cyc_q[CW-1:2], 1'b0});
      xl      = xe | {10'd0, cyc_q[1] & cyc_q[0]};
      ya      = {1'b0, line_q};
      // 11-bit sums: a marker hanging off the frame is clipped, never wrapped.
      in_mark = (xe >= {1'b0, mx_q}) && (xe < ({1'b0, mx_q} + MS)) &&
                (ya >= {1'b0, my_q}) && (ya < ({1'b0, my_q} + MS));
      c_tab   = bar_ycc(bar_of(xe));
      l_tab   = bar_ycc(bar_of(xl));
      y_v     = 8'h80;
      cb_v    = 8'h80;
      cr_v    = 8'h80;
      case (mode_q)
         2'd1: begin
            y_v  = l_tab[23:16];
            cb_v = c_tab[15:8];
            cr_v = c_tab[7:0];
         end
         2'd2: y_v = xl[9:2];
         2'd3: begin
            y_v  = in_mark ? 8'hC0 : 8'h40;
            cb_v = in_mark ? 8'hC8 : 8'h80;
            cr_v = in_mark ? 8'hC8 : 8'h80;
         end
         default: ;
      endcase
      href_d = (state_q == ACTIVE) && (cyc_q < HREF_END);
      pix_d  = 8'h00;
      if (href_d) begin
         case (cyc_q[1:0])
            2'd0:    pix_d = cb_v;
            2'd2:    pix_d = cr_v;
            default: pix_d = y_v;
         endcase
      end
   end

   always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         line_q  <= '0;
         mode_q  <= '0;
         mx_q    <= '0;
         my_q    <= '0;
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
         pix_q   <= 8'h00;
         done_q  <= 1'b0;
         fcnt_q  <= 8'h00;
      end else begin
         vsync_q <= (state_q == VSYNC);
         href_q  <= href_d;
         pix_q   <= pix_d;
         done_q  <= 1'b0;
         if (state_q == IDLE) begin
            cyc_q  <= '0;
            line_q <= '0;
            if (bus.enable) begin
               state_q <= VSYNC;
               mode_q  <= bus.mode;
               mx_q    <= bus.marker_x;
               my_q    <= bus.marker_y;
            end
         end else begin
            cyc_q  <= cyc_d;
            line_q <= line_d;
            if (blk_end) begin
               case (state_q)
                  VSYNC:  state_q <= VBACK;
                  VBACK:  state_q <= ACTIVE;
                  ACTIVE: state_q <= VFRONT;
                  VFRONT: begin
                     done_q <= 1'b1;
                     fcnt_q <= fcnt_q + 8'd1;
                     // Pattern controls only change at frame boundaries.
                     if (bus.enable) begin
                        state_q <= VSYNC;
                        mode_q  <= bus.mode;
                        mx_q    <= bus.marker_x;
                        my_q    <= bus.marker_y;
                     end else begin
                        state_q <= IDLE;
                     end
                  end
                  default: state_q <= IDLE;
               endcase
            end
         end
      end
   end

   assign bus.cam_vsync   = vsync_q;
   assign bus.href        = href_q;
   assign bus.pixel       = pix_q;
   assign bus.frame_done  = done_q;
   assign bus.frame_count = fcnt_q;

endmodule

// File: tb/tb_cam_stream_source.sv
// Bench for cam_stream_source with a shortened vertical frame (full 640-pixel
// lines) so several frames fit in a short run. A frame-position reference
// model predicts every output on every cycle.
module tb_cam_stream_source;
   localparam int HA = 640, VA = 6, HB = 16, VS = 2, VB = 1, VF = 1, MS = 4;
   localparam int LINE  = 2*HA + HB;
   localparam int FRAME = (VS + VB + VA + VF) * LINE;

   localparam logic [7:0] BY [0:7] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};
   localparam logic [7:0] BC [0:7] = '{8'h80, 8'h10, 8'hA6, 8'h36, 8'hCA, 8'h5A, 8'hF0, 8'h80};
   localparam logic [7:0] BR [0:7] = '{8'h80, 8'h92, 8'h10, 8'h22, 8'hDE, 8'hF0, 8'h6E, 8'h80};

   logic pclk = 1'b0;
   logic reset;
   cam_stream_if bus();

   cam_stream_source #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VSYNC_LINES(VS),
      .V_BACK(VB), .V_FRONT(VF), .MARK_SIZE(MS)
   ) dut (
      .pclk  (pclk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 pclk = ~pclk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: running flag, position within frame, latched controls.
   bit          m_run;
   int          m_pos, m_cnt, sh_mode, sh_mx, sh_my;
   logic [18:0] exp_v, obs_v;

   function automatic logic [7:0] exp_pix(int c, int ya, int m, int mx, int my);
      int xe, x, ph;
      bit inm;
      logic [7:0] y, cb, cr;
      ph = c % 4;
      xe = (c / 4) * 2;
      x  = (ph == 3) ? xe + 1 : xe;
      y = 8'h80; cb = 8'h80; cr = 8'h80;
      case (m)
         1: begin y = BY[x/80]; cb = BC[xe/80]; cr = BR[xe/80]; end
         2: y = 8'(x / 4);
         3: begin
            inm = (xe >= mx) && (xe < mx + MS) && (ya >= my) && (ya < my + MS);
            y  = inm ? 8'hC0 : 8'h40;
            cb = inm ? 8'hC8 : 8'h80;
            cr = inm ? 8'hC8 : 8'h80;
         end
         default: ;
      endcase
      case (ph)
         0:       return cb;
         2:       return cr;
         default: return y;
      endcase
   endfunction

   task automatic latch_ctl();
      sh_mode = int'(bus.mode);
      sh_mx   = int'(bus.marker_x);
      sh_my   = int'(bus.marker_y);
   endtask

   // Model state advance at a rising edge; exp_v is what the DUT must show.
   task automatic model_edge();
      int ln, c;
      bit vs, hr, fd;
      logic [7:0] px;
      if (!reset) begin
         m_run = 0; m_pos = 0; m_cnt = 0;
         exp_v = '0;
         return;
      end
      ln = m_pos / LINE;
      c  = m_pos % LINE;
      vs = m_run && (ln < VS);
      hr = m_run && (ln >= VS + VB) && (ln < VS + VB + VA) && (c < 2*HA);
      px = hr ? exp_pix(c, ln - VS - VB, sh_mode, sh_mx, sh_my) : 8'h00;
      fd = m_run && (m_pos == FRAME - 1);
      if (fd) m_cnt = (m_cnt + 1) % 256;
      exp_v = {vs, hr, px, fd, 8'(m_cnt)};
      if (!m_run) begin
         if (bus.enable) begin m_run = 1; m_pos = 0; latch_ctl(); end
      end else if (m_pos == FRAME - 1) begin
         if (bus.enable) begin m_pos = 0; latch_ctl(); end
         else m_run = 0;
      end else begin
         m_pos++;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk);
         model_edge();
         #1;
         obs_v = {bus.cam_vsync, bus.href, bus.pixel, bus.frame_done, bus.frame_count};
         n_vec++;
         assert (obs_v === exp_v) else begin
            n_bad++;
            $error("FAIL stream t=%0t pos=%0d obs vs=%0b hr=%0b px=%02h fd=%0b fc=%0d exp vs=%0b hr=%0b px=%02h fd=%0b fc=%0d",
                   $time, m_pos, obs_v[18], obs_v[17], obs_v[16:9], obs_v[8], obs_v[7:0],
                   exp_v[18], exp_v[17], exp_v[16:9], exp_v[8], exp_v[7:0]);
         end
      end
   endtask

   initial begin
      reset        = 1'b0;
      bus.enable   = 1'b1;
      bus.mode     = 2'd0;
      bus.marker_x = 10'd0;
      bus.marker_y = 10'd0;
      step(3);                               // reset state
      reset = 1'b1;
      step(FRAME / 2);                       // frame 1: solid gray
      bus.mode = 2'd1;                       // mid-frame change, applies to frame 2
      step(FRAME);                           // frame 1 tail + frame 2 head (bars)
      bus.mode = 2'd3; bus.marker_x = 10'd100; bus.marker_y = 10'd2;
      step(FRAME);                           // frame 2 tail + frame 3 (marker)
      bus.mode     = 2'd3;                   // marker clipped at right edge
      bus.marker_x = 10'($urandom_range(600, 1023));
      bus.marker_y = 10'($urandom_range(0, 7));
      step(FRAME);
      bus.mode     = 2'($urandom_range(0, 3));
      bus.marker_x = 10'($urandom_range(0, 639));
      bus.marker_y = 10'($urandom_range(0, 5));
      step(FRAME / 2 + 4*LINE + 100);        // into ACTIVE of the next frame
      bus.enable = 1'b0;                     // frame must still complete
      bus.mode   = 2'($urandom_range(0, 3));
      step(FRAME - (4*LINE + 100) + 300);    // frame end, then idle zeros
      bus.enable = 1'b1;
      bus.mode   = 2'd2;
      step(3*LINE + 50);                     // mid active line, luma ramp
      #2;
      reset = 1'b0;                          // async: no edge needed
      #1;
      obs_v = {bus.cam_vsync, bus.href, bus.pixel, bus.frame_done, bus.frame_count};
      n_vec++;
      assert (obs_v === 19'd0) else begin
         n_bad++;
         $error("FAIL async_reset obs=%05h exp=00000", obs_v);
      end
      step(4);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
